// File: rtl/accel_averager.sv
// accel_averager: samples the driver's X/Y/Z registers atomically on a fixed
// tick, block-averages 2^Log2_N samples per axis through one shared adder and
// emits the averages with a single-cycle Valid strobe.
// Optional motion detector: define ACCEL_AVERAGER_MOTION_DETECT_EN to enable
// the Compare state and the Motion pulse (Motion is tied low otherwise).
module accel_averager #(
  parameter int          Sample_Div       = 50000,
  parameter int          Log2_N           = 3,
  parameter logic [18:0] Motion_Threshold = 19'd64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [15:0] Z,
  output logic [15:0] X_Avg,
  output logic [15:0] Y_Avg,
  output logic [15:0] Z_Avg,
  output logic        Valid,
  output logic        Motion
);

  // Accumulators are wide enough that 2^Log2_N sign-extended samples never overflow.
  localparam int AccW = 16 + Log2_N;
  localparam int CntW = $clog2(Sample_Div + 1);

  localparam logic [CntW-1:0]   DIV_LAST = CntW'(Sample_Div);
  localparam logic [CntW-1:0]   DIV_ONE  = CntW'(1);
  localparam logic [Log2_N-1:0] CNT_LAST = '1;
  localparam logic [Log2_N-1:0] CNT_ONE  = Log2_N'(1);

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_SUMX = 3'd1;
  localparam logic [2:0] ST_SUMY = 3'd2;
  localparam logic [2:0] ST_SUMZ = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
`ifdef ACCEL_AVERAGER_MOTION_DETECT_EN
  localparam logic [2:0] ST_CMP  = 3'd5;
  localparam logic [2:0] ST_AFTER_OUT = ST_CMP;
`else
  localparam logic [2:0] ST_AFTER_OUT = ST_WAIT;
`endif

  logic [CntW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                     tick;
  logic [2:0]               state_q, state_d;
  logic [Log2_N-1:0]        smp_cnt_q, smp_cnt_d;
  logic [15:0]              snap_x_q, snap_x_d;
  logic [15:0]              snap_y_q, snap_y_d;
  logic [15:0]              snap_z_q, snap_z_d;
  logic signed [AccW-1:0]   acc_x_q, acc_x_d;
  logic signed [AccW-1:0]   acc_y_q, acc_y_d;
  logic signed [AccW-1:0]   acc_z_q, acc_z_d;
  logic [15:0]              x_avg_q, x_avg_d;
  logic [15:0]              y_avg_q, y_avg_d;
  logic [15:0]              z_avg_q, z_avg_d;
  logic                     valid_q, valid_d;
  logic signed [AccW-1:0]   add_a, add_b, add_sum;

  // Sample tick: counter runs 1..Sample_Div, tick on the terminal count.
  always_comb begin
    tick       = (tick_cnt_q == DIV_LAST);
    tick_cnt_d = tick ? DIV_ONE : tick_cnt_q + DIV_ONE;
  end

  // Shared accumulate adder: operands steered by the axis currently being summed.
  always_comb begin
    add_a = acc_x_q;
    add_b = {{Log2_N{snap_x_q[15]}}, snap_x_q};
    case (state_q)
      ST_SUMY: begin
        add_a = acc_y_q;
        add_b = {{Log2_N{snap_y_q[15]}}, snap_y_q};
      end
      ST_SUMZ: begin
        add_a = acc_z_q;
        add_b = {{Log2_N{snap_z_q[15]}}, snap_z_q};
      end
      default: ;
    endcase
    add_sum = add_a + add_b;
  end

  // Sequencer: snapshot on tick, one axis per cycle, then publish averages.
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    snap_z_d  = snap_z_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    acc_z_d   = acc_z_q;
    x_avg_d   = x_avg_q;
    y_avg_d   = y_avg_q;
    z_avg_d   = z_avg_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (tick) begin
          snap_x_d = X;
          snap_y_d = Y;
          snap_z_d = Z;
          state_d  = ST_SUMX;
        end
      end
      ST_SUMX: begin
        acc_x_d = add_sum;
        state_d = ST_SUMY;
      end
      ST_SUMY: begin
        acc_y_d = add_sum;
        state_d = ST_SUMZ;
      end
      ST_SUMZ: begin
        acc_z_d = add_sum;
        if (smp_cnt_q == CNT_LAST) begin
          state_d = ST_OUT;
        end else begin
          smp_cnt_d = smp_cnt_q + CNT_ONE;
          state_d   = ST_WAIT;
        end
      end
      ST_OUT: begin
        // Arithmetic shift: averages round toward -infinity.
        x_avg_d   = 16'(acc_x_q >>> Log2_N);
        y_avg_d   = 16'(acc_y_q >>> Log2_N);
        z_avg_d   = 16'(acc_z_q >>> Log2_N);
        valid_d   = 1'b1;
        acc_x_d   = '0;
        acc_y_d   = '0;
        acc_z_d   = '0;
        smp_cnt_d = '0;
        state_d   = ST_AFTER_OUT;
      end
`ifdef ACCEL_AVERAGER_MOTION_DETECT_EN
      ST_CMP: begin
        state_d = ST_WAIT;
      end
`endif
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      state_q    <= ST_WAIT;
      smp_cnt_q  <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_z_q    <= '0;
      x_avg_q    <= '0;
      y_avg_q    <= '0;
      z_avg_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_z_q   <= snap_z_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_z_q    <= acc_z_d;
      x_avg_q    <= x_avg_d;
      y_avg_q    <= y_avg_d;
      z_avg_q    <= z_avg_d;
      valid_q    <= valid_d;
    end
  end

  assign X_Avg = x_avg_q;
  assign Y_Avg = y_avg_q;
  assign Z_Avg = z_avg_q;
  assign Valid = valid_q;

`ifdef ACCEL_AVERAGER_MOTION_DETECT_EN
  logic [15:0] prev_x_q, prev_x_d;
  logic [15:0] prev_y_q, prev_y_d;
  logic [15:0] prev_z_q, prev_z_d;
  logic        have_avg_q, have_avg_d;
  logic        prev_valid_q, prev_valid_d;
  logic        motion_q, motion_d;
  logic [16:0] dif_x, dif_y, dif_z;
  logic [16:0] mag_x, mag_y, mag_z;
  logic [18:0] dist;

  // Manhattan distance between the new averages and the previous ones.
  always_comb begin
    dif_x = {x_avg_q[15], x_avg_q} - {prev_x_q[15], prev_x_q};
    dif_y = {y_avg_q[15], y_avg_q} - {prev_y_q[15], prev_y_q};
    dif_z = {z_avg_q[15], z_avg_q} - {prev_z_q[15], prev_z_q};
    mag_x = dif_x[16] ? (17'd0 - dif_x) : dif_x;
    mag_y = dif_y[16] ? (17'd0 - dif_y) : dif_y;
    mag_z = dif_z[16] ? (17'd0 - dif_z) : dif_z;
    dist  = {2'b00, mag_x} + {2'b00, mag_y} + {2'b00, mag_z};
  end

  // Prev capture on Output; Motion decided in Compare, suppressed until a Prev exists.
  always_comb begin
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_z_d     = prev_z_q;
    have_avg_d   = have_avg_q;
    prev_valid_d = prev_valid_q;
    motion_d     = 1'b0;
    if (state_q == ST_OUT) begin
      prev_x_d     = x_avg_q;
      prev_y_d     = y_avg_q;
      prev_z_d     = z_avg_q;
      prev_valid_d = have_avg_q;
      have_avg_d   = 1'b1;
    end
    if (state_q == ST_CMP) begin
      motion_d = prev_valid_q && (dist > Motion_Threshold);
    end
  end

  // Motion detector registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_z_q     <= '0;
      have_avg_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      motion_q     <= 1'b0;
    end else begin
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_z_q     <= prev_z_d;
      have_avg_q   <= have_avg_d;
      prev_valid_q <= prev_valid_d;
      motion_q     <= motion_d;
    end
  end

  assign Motion = motion_q;
`else
  // Threshold only matters to the motion detector.
  logic unused_threshold;
  assign unused_threshold = ^Motion_Threshold;
  assign Motion = 1'b0;
`endif

endmodule

// File: tb/tb_accel_averager.sv
// Self-checking bench for accel_averager: randomized window stimulus checked
// every cycle against an arithmetic reference model (floor of the window mean).
`timescale 1ns/1ps
module tb_accel_averager;

  localparam int SD = 10;
  localparam int LN = 3;
  localparam int NS = 1 << LN;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, y, z;
  logic [15:0] xa, ya, za;
  logic        valid, motion;

  always #5 clk = ~clk;

  accel_averager #(
    .Sample_Div(SD),
    .Log2_N(LN),
    .Motion_Threshold(19'd64)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .X(x),
    .Y(y),
    .Z(z),
    .X_Avg(xa),
    .Y_Avg(ya),
    .Z_Avg(za),
    .Valid(valid),
    .Motion(motion)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc;                 // cycles since reset release
  int          qx[$], qy[$], qz[$]; // samples of the current window
  logic        pend_v = 1'b0;
  int          due_v = -1;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        pend_m = 1'b0;
  int          due_m = -1;
  int          last_x, last_y, last_z;
  logic        have_avg = 1'b0;

  function automatic int avg_of(input int axis, input int cur);
    int s = cur;
    for (int i = 0; i < qx.size(); i++)
      s += (axis == 0) ? qx[i] : (axis == 1) ? qy[i] : qz[i];
    return (s >= 0) ? s / NS : -((-s + NS - 1) / NS);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int dist_of(input int ax, input int ay, input int az);
    return iabs(ax - last_x) + iabs(ay - last_y) + iabs(az - last_z);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
      qx.delete(); qy.delete(); qz.delete();
      pend_v   <= 1'b0;
      pend_m   <= 1'b0;
      have_avg <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (cyc > 0 && cyc % SD == 0) begin
        if (qx.size() == NS - 1) begin
          pend_x <= 16'(avg_of(0, int'($signed(x))));
          pend_y <= 16'(avg_of(1, int'($signed(y))));
          pend_z <= 16'(avg_of(2, int'($signed(z))));
          pend_v <= 1'b1;
          due_v  <= cyc + 5;
`ifdef ACCEL_AVERAGER_MOTION_DETECT_EN
          pend_m <= have_avg && (dist_of(avg_of(0, int'($signed(x))),
                                         avg_of(1, int'($signed(y))),
                                         avg_of(2, int'($signed(z)))) > 64);
          due_m  <= cyc + 6;
`endif
          last_x   <= avg_of(0, int'($signed(x)));
          last_y   <= avg_of(1, int'($signed(y)));
          last_z   <= avg_of(2, int'($signed(z)));
          have_avg <= 1'b1;
          qx.delete(); qy.delete(); qz.delete();
        end else begin
          qx.push_back(int'($signed(x)));
          qy.push_back(int'($signed(y)));
          qz.push_back(int'($signed(z)));
        end
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  logic [15:0] exp_x = '0, exp_y = '0, exp_z = '0;
  wire         due_now  = pend_v && (cyc == due_v);
  wire         mot_now  = pend_m && (cyc == due_m);
  wire  [15:0] want_x   = due_now ? pend_x : exp_x;
  wire  [15:0] want_y   = due_now ? pend_y : exp_y;
  wire  [15:0] want_z   = due_now ? pend_z : exp_z;

  always @(negedge clk) begin
    if (rst) begin
      exp_x <= '0;
      exp_y <= '0;
      exp_z <= '0;
    end else begin
      chk("valid", 32'(valid), 32'(due_now));
      chk("x_avg", 32'(xa), 32'(want_x));
      chk("y_avg", 32'(ya), 32'(want_y));
      chk("z_avg", 32'(za), 32'(want_z));
      chk("motion", 32'(motion), 32'(mot_now));
      if (due_now) begin
        exp_x <= pend_x;
        exp_y <= pend_y;
        exp_z <= pend_z;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_sample(input int mode, input int k);
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    case (mode)
      0: begin x = 16'd100; y = 16'hFFCE; z = 16'd256; end
      1: begin x = 16'(k); y = 16'(-k); z = 16'(k * 1000); end
      2: begin x = (k < 7) ? 16'hFFFF : 16'h0000; y = 16'(k - 4); z = 16'(-3 * k); end
      3: begin x = 16'h7FFF; y = 16'h8000; z = (k % 2 == 1) ? 16'h7FFF : 16'h8000; end
      5: x = 16'd10;
      6: begin x = 16'd0;   y = '0; z = '0; end
      7: begin x = 16'd100; y = '0; z = '0; end
      8: begin x = 16'd100; y = '0; z = '0; end
      9: begin x = 16'd164; y = '0; z = '0; end
      default: ;
    endcase
  endtask

  // Drive n tick samples of the given mode; non-tick cycles carry junk.
  task automatic run_ticks(input int mode, input int n);
    int got = 0;
    while (got < n) begin
      @(posedge clk); #1;
      if (cyc > 0 && cyc % SD == 0) begin
        set_sample(mode, qx.size());
        got++;
      end else begin
        x = (mode == 5) ? 16'd1000 : 16'($urandom);
        y = 16'($urandom);
        z = 16'($urandom);
      end
    end
  endtask

  // From the final tick cycle T, land mid-cycle T+5.
  task automatic wait_out();
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_xavg", 32'(xa), 32'd0);
    chk("rst_motion", 32'(motion), 32'd0);
  endtask

  logic [3:0] mot_want;

  initial begin
    rst = 1'b1; x = '0; y = '0; z = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_yavg", 32'(ya), 32'd0);

    run_ticks(0, 8); wait_out();
    chk("const_valid", 32'(valid), 32'd1);
    chk("const_x", 32'(xa), 32'd100);
    chk("const_y", 32'(ya), 32'hFFCE);
    chk("const_z", 32'(za), 32'd256);
    run_ticks(0, 8);

    run_ticks(1, 8); wait_out();
    chk("ramp_x", 32'(xa), 32'd3);
    run_ticks(2, 8); wait_out();
    chk("floor_x", 32'(xa), 32'hFFFF);
    run_ticks(3, 8); wait_out();
    chk("max_x", 32'(xa), 32'h7FFF);
    chk("min_y", 32'(ya), 32'h8000);

    run_ticks(4, 5);
    do_reset();
    run_ticks(1, 8); wait_out();
    chk("postrst_x", 32'(xa), 32'd3);

    run_ticks(5, 8); wait_out();
    chk("isolate_x", 32'(xa), 32'd10);

    for (int w = 0; w < 3; w++) run_ticks(4, 8);

    do_reset();
`ifdef ACCEL_AVERAGER_MOTION_DETECT_EN
    mot_want = 4'b0010;
`else
    mot_want = 4'b0000;
`endif
    for (int w = 0; w < 4; w++) begin
      run_ticks(6 + w, 8); wait_out();
      @(negedge clk);
      chk($sformatf("motion_w%0d", w + 1), 32'(motion), 32'(mot_want[w]));
    end

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_averager.md
Name: accel_averager

Overview:
- Downstream consumer of the ADXL345 SPI driver's free-running X/Y/Z 2's-complement registers.
- Samples all three axes atomically at a fixed rate and block-averages 2^Log2_N samples per axis using one shared accumulate adder.
- Emits decimated averages with a one-cycle Valid strobe for display/UART stages.

Parameters:
- Sample_Div, 50000, clocks between sample ticks (1 kHz at 50 MHz); must be >= 8.
- Log2_N, 3, log2 of samples per average (1..8).
- Motion_Threshold, 64, motion limit in LSB, 19-bit unsigned; used only with the optional feature.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- X  input  16  signed X acceleration from the driver
- Y  input  16  signed Y acceleration
- Z  input  16  signed Z acceleration
- X_Avg  output  16  signed averaged X
- Y_Avg  output  16  signed averaged Y
- Z_Avg  output  16  signed averaged Z
- Valid  output  1  one-cycle pulse; new averages present
- Motion  output  1  one-cycle motion event pulse; tied 0 without the optional feature

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset state: X_Avg/Y_Avg/Z_Avg = 0, Valid = 0, Motion = 0, accumulators = 0, sample count = 0, tick counter = 0, state = Wait.
- Reset mid-window discards all partial sums.
- Tick counter: counts 1..Sample_Div. Tick is high for one cycle when count == Sample_Div, then the counter reloads to 1. First tick occurs Sample_Div cycles after reset release.
- Accumulators: three signed registers, 16+Log2_N bits wide. Inputs are sign-extended, so there is never overflow or saturation.
- State machine, one axis per cycle through the shared adder:
  - Wait: on tick, snapshot X, Y, Z into internal registers in that same cycle, then go to SumX. Otherwise stay in Wait.
  - SumX: AccX += SnapX, then go to SumY.
  - SumY: AccY += SnapY, then go to SumZ.
  - SumZ: AccZ += SnapZ. If sample count == 2^Log2_N - 1, go to Output. Otherwise increment the count and go to Wait.
  - Output:
    - Load X_Avg = AccX >>> Log2_N, and likewise for Y and Z. This is an arithmetic shift, so results round toward -infinity.
    - Assert Valid, clear accumulators and sample count.
    - Go to Compare (feature enabled) or Wait (feature disabled).
- Timing:
  - Tick of the final window sample in cycle T.
  - Averages and Valid appear in cycle T+5.
  - Valid is high exactly one cycle. Averages hold until the next Output.
- Snapshot isolation: input changes after the tick cycle do not affect the current sample.
- Tick outside Wait cannot occur given Sample_Div >= 8. Sample_Div < 8 is unsupported.

Optional Feature:
- Macro: ACCEL_AVERAGER_MOTION_DETECT_EN.
- Defined:
  - Output state also copies the previous X_Avg/Y_Avg/Z_Avg into Prev registers.
  - Compare state computes D = |X_Avg-PrevX| + |Y_Avg-PrevY| + |Z_Avg-PrevZ|, using 17-bit differences and a 19-bit sum.
  - Motion pulses for one cycle (T+6) if D > Motion_Threshold. Equality does not fire.
  - Compare then goes to Wait.
  - No Motion on the first average after reset; a Prev-valid flag is cleared by reset.
- Undefined: no Compare state, no Prev registers, Motion is constant 0.

Test Plan:
- Sample_Div=10, Log2_N=3; constant X=100, Y=-50 (0xFFCE), Z=256 -> after 8 ticks, Valid high one cycle; X_Avg=100, Y_Avg=0xFFCE, Z_Avg=256; next Valid 80 cycles later.
- X sequence 0..7 -> X_Avg=3. X = seven samples of -1 then one 0 -> X_Avg=0xFFFF (-1, floor).
- Extremes: all X=0x7FFF -> X_Avg=0x7FFF. All Y=0x8000 -> Y_Avg=0x8000. No wrap.
- Reset pulsed after 5 ticks -> outputs 0, Valid stays low until 8 fresh ticks after release; average reflects only post-reset samples.
- Change X from 10 to 1000 the cycle after every tick, restoring it before the next tick -> X_Avg=10.
- With the macro: window 1 all 0 -> no Motion. Window 2 X=100 -> Motion pulse at T+6 (D=100>64). Window 3 X=100 -> no Motion. Window 4 X=164 -> no Motion (D=64). Without the macro, Motion is never high.
